// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding-select, load-use stall and branch-flush control
// for the 5-stage pipeline. Keeps a shadow copy of the destination info held
// in EX and MEM and drives the EX operand MUX_4 selects.
module fwd_hazard_ctrl #(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_reg_write,
   input  logic             id_is_load,
   input  logic             ex_br_taken,
   input  logic             ext_hold,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             stall,
   output logic             flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      HOLD     = 2'd2
   } state_t;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             reg_write;
      logic             is_load;
   } stage_t;

   localparam logic [1:0] SEL_RF  = 2'd0;
   localparam logic [1:0] SEL_EXM = 2'd1;
   localparam logic [1:0] SEL_MWB = 2'd2;

   // The regfile is write-through, so a WB-stage producer never needs a
   // forwarding path; only EX and MEM entries are shadowed.
   stage_t ex_q;
   stage_t mem_q;
   stage_t id_entry;

   state_t state;
   state_t saved;
   state_t state_nxt;
   state_t saved_nxt;
   state_t eff_state;

   logic       ex_hit_rs;
   logic       ex_hit_rt;
   logic       mem_hit_rs;
   logic       mem_hit_rt;
   logic       load_use;
   logic       issue;
   logic [1:0] sel_a_nxt;
   logic [1:0] sel_b_nxt;

   function automatic logic writes(input stage_t s, input logic [REG_W-1:0] r);
      return s.valid & s.reg_write & (s.rd == r) & (r != '0);
   endfunction

   // Hazard detection, stall/flush generation and next forwarding selects.
   always_comb begin
      ex_hit_rs  = id_use_rs & writes(ex_q, id_rs);
      ex_hit_rt  = id_use_rt & writes(ex_q, id_rt);
      mem_hit_rs = id_use_rs & writes(mem_q, id_rs);
      mem_hit_rt = id_use_rt & writes(mem_q, id_rt);

      // While parked in HOLD, behave as the state that was interrupted.
      eff_state = (state == HOLD) ? saved : state;

      load_use = id_valid & ex_q.valid & ex_q.is_load & (ex_hit_rs | ex_hit_rt);
      flush    = ex_br_taken & ~ext_hold;
      stall    = load_use & ~ex_br_taken & ~ext_hold & (eff_state != LU_STALL);
      issue    = id_valid & ~stall & ~flush;

      sel_a_nxt = ex_hit_rs ? SEL_EXM : (mem_hit_rs ? SEL_MWB : SEL_RF);
      sel_b_nxt = ex_hit_rt ? SEL_EXM : (mem_hit_rt ? SEL_MWB : SEL_RF);

      id_entry.valid     = 1'b1;
      id_entry.rd        = id_rd;
      id_entry.reg_write = id_reg_write;
      id_entry.is_load   = id_is_load;
   end

   // FSM next state: RUN -> LU_STALL for one cycle on a stall; any state
   // parks in HOLD while frozen and resumes the saved state on release.
   always_comb begin
      state_nxt = state;
      saved_nxt = saved;
      if (ext_hold) begin
         state_nxt = HOLD;
         saved_nxt = (state == HOLD) ? saved : state;
      end else begin
         saved_nxt = RUN;
         case (eff_state)
            RUN:      state_nxt = stall ? LU_STALL : RUN;
            LU_STALL: state_nxt = RUN;
            default:  state_nxt = RUN;
         endcase
      end
   end

   // State register, shadow pipe advance, select registers and counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= RUN;
         saved     <= RUN;
         ex_q      <= '0;
         mem_q     <= '0;
         fwd_a_sel <= SEL_RF;
         fwd_b_sel <= SEL_RF;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= state_nxt;
         saved <= saved_nxt;
         if (!ext_hold) begin
            mem_q <= ex_q;
            if (issue) begin
               ex_q      <= id_entry;
               fwd_a_sel <= sel_a_nxt;
               fwd_b_sel <= sel_b_nxt;
            end else begin
               ex_q      <= '0;
               fwd_a_sel <= SEL_RF;
               fwd_b_sel <= SEL_RF;
            end
            if (stall && (stall_cnt != '1))
               stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (flush && (flush_cnt != '1))
               flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule
